// File: rtl/slot_sequencer_pkg.sv
// rtl/slot_sequencer_pkg.sv - shared slot status and sequencer state encodings
package slot_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_READY = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } slot_status_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT      = 3'd3,
        S_WRITEBACK = 3'd4,
        S_FINISH    = 3'd5
    } seq_state_e;

endpackage

// File: rtl/slot_sequencer_profile.sv
// rtl/slot_sequencer_profile.sv - saturating elapsed-cycle counter for one slot
module seq_profile_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;

    // Holds at all-ones so a very long transfer reports the maximum instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !(&count_q)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/slot_sequencer.sv
// rtl/slot_sequencer.sv - walks a slot range, issues MM2S/S2MM commands, writes back status and profile
module slot_sequencer
    import slot_sequencer_pkg::*;
#(
    parameter int INDEX_WIDTH    = 3,
    parameter int SRC_ADDR_WIDTH = 32,
    parameter int SRC_SIZE_WIDTH = 26,
    parameter int DST_ADDR_WIDTH = 32,
    parameter int DST_SIZE_WIDTH = 26,
    parameter int STATUS_WIDTH   = 2,
    parameter int PROFILE_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [INDEX_WIDTH-1:0]    start_index,
    input  logic [INDEX_WIDTH:0]      slot_count,
    output logic                      busy,
    output logic                      done,
    output logic                      run_err,
    output logic [INDEX_WIDTH-1:0]    rd_index,
    input  logic [SRC_ADDR_WIDTH-1:0] rd_src_addr,
    input  logic [SRC_SIZE_WIDTH-1:0] rd_src_size,
    input  logic [DST_ADDR_WIDTH-1:0] rd_des_addr,
    input  logic [DST_SIZE_WIDTH-1:0] rd_des_size,
    input  logic [STATUS_WIDTH-1:0]   rd_status,
    output logic [INDEX_WIDTH-1:0]    wr_index,
    output logic [STATUS_WIDTH-1:0]   wr_status,
    output logic [PROFILE_WIDTH-1:0]  wr_profile,
    output logic                      set_status,
    output logic                      set_profile,
    output logic                      mm2s_valid,
    input  logic                      mm2s_ready,
    output logic [SRC_ADDR_WIDTH-1:0] mm2s_addr,
    output logic [SRC_SIZE_WIDTH-1:0] mm2s_size,
    input  logic                      mm2s_done,
    input  logic                      mm2s_err,
    output logic                      s2mm_valid,
    input  logic                      s2mm_ready,
    output logic [DST_ADDR_WIDTH-1:0] s2mm_addr,
    output logic [DST_SIZE_WIDTH-1:0] s2mm_size,
    input  logic                      s2mm_done,
    input  logic                      s2mm_err
);
    localparam logic [INDEX_WIDTH-1:0]  IDX_ONE     = INDEX_WIDTH'(1);
    localparam logic [INDEX_WIDTH:0]    REM_ONE     = (INDEX_WIDTH + 1)'(1);
    localparam logic [STATUS_WIDTH-1:0] STAT_READY  = STATUS_WIDTH'(ST_READY);
    localparam logic [STATUS_WIDTH-1:0] STAT_DONE   = STATUS_WIDTH'(ST_DONE);
    localparam logic [STATUS_WIDTH-1:0] STAT_ERROR  = STATUS_WIDTH'(ST_ERROR);

    seq_state_e                state_q, state_d;
    logic [INDEX_WIDTH-1:0]    cur_q, cur_d;
    logic [INDEX_WIDTH:0]      rem_q, rem_d;
    logic [SRC_ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
    logic [SRC_SIZE_WIDTH-1:0] src_size_q, src_size_d;
    logic [DST_ADDR_WIDTH-1:0] des_addr_q, des_addr_d;
    logic [DST_SIZE_WIDTH-1:0] des_size_q, des_size_d;
    logic                      mm2s_valid_q, mm2s_valid_d;
    logic                      s2mm_valid_q, s2mm_valid_d;
    logic                      src_cmp_q, src_cmp_d;
    logic                      dst_cmp_q, dst_cmp_d;
    logic                      slot_err_q, slot_err_d;
    logic                      run_err_q, run_err_d;
    logic                      cnt_clear;
    logic                      cnt_enable;
    logic [PROFILE_WIDTH-1:0]  cnt_value;

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        rem_d        = rem_q;
        src_addr_d   = src_addr_q;
        src_size_d   = src_size_q;
        des_addr_d   = des_addr_q;
        des_size_d   = des_size_q;
        mm2s_valid_d = mm2s_valid_q;
        s2mm_valid_d = s2mm_valid_q;
        src_cmp_d    = src_cmp_q;
        dst_cmp_d    = dst_cmp_q;
        slot_err_d   = slot_err_q;
        run_err_d    = run_err_q;
        cnt_clear    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    run_err_d = 1'b0;
                    if (slot_count == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        cur_d   = start_index;
                        rem_d   = slot_count;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                src_addr_d = rd_src_addr;
                src_size_d = rd_src_size;
                des_addr_d = rd_des_addr;
                des_size_d = rd_des_size;
                if (rd_status != STAT_READY) begin
                    run_err_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    cnt_clear    = 1'b1;
                    mm2s_valid_d = (rd_src_size != '0);
                    s2mm_valid_d = (rd_des_size != '0);
                    src_cmp_d    = (rd_src_size == '0);
                    dst_cmp_d    = (rd_des_size == '0);
                    slot_err_d   = 1'b0;
                    state_d      = S_ISSUE;
                end
            end
            // Completions are captured in ISSUE too, so a done that races its handshake is kept.
            S_ISSUE, S_WAIT: begin
                if (mm2s_valid_q && mm2s_ready) mm2s_valid_d = 1'b0;
                if (s2mm_valid_q && s2mm_ready) s2mm_valid_d = 1'b0;
                if (mm2s_done) begin
                    src_cmp_d = 1'b1;
                    if (mm2s_err) slot_err_d = 1'b1;
                end
                if (s2mm_done) begin
                    dst_cmp_d = 1'b1;
                    if (s2mm_err) slot_err_d = 1'b1;
                end
                if (!mm2s_valid_d && !s2mm_valid_d) begin
                    state_d = (src_cmp_d && dst_cmp_d) ? S_WRITEBACK : S_WAIT;
                end
            end
            S_WRITEBACK: begin
                rem_d = rem_q - REM_ONE;
                if (slot_err_q) begin
                    run_err_d = 1'b1;
                    state_d   = S_FINISH;
                end else if (rem_q == REM_ONE) begin
                    state_d = S_FINISH;
                end else begin
                    cur_d   = cur_q + IDX_ONE;
                    state_d = S_FETCH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            rem_q        <= '0;
            src_addr_q   <= '0;
            src_size_q   <= '0;
            des_addr_q   <= '0;
            des_size_q   <= '0;
            mm2s_valid_q <= 1'b0;
            s2mm_valid_q <= 1'b0;
            src_cmp_q    <= 1'b0;
            dst_cmp_q    <= 1'b0;
            slot_err_q   <= 1'b0;
            run_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            rem_q        <= rem_d;
            src_addr_q   <= src_addr_d;
            src_size_q   <= src_size_d;
            des_addr_q   <= des_addr_d;
            des_size_q   <= des_size_d;
            mm2s_valid_q <= mm2s_valid_d;
            s2mm_valid_q <= s2mm_valid_d;
            src_cmp_q    <= src_cmp_d;
            dst_cmp_q    <= dst_cmp_d;
            slot_err_q   <= slot_err_d;
            run_err_q    <= run_err_d;
        end
    end

    assign cnt_enable = (state_q == S_ISSUE) || (state_q == S_WAIT);

    seq_profile_counter #(
        .WIDTH (PROFILE_WIDTH)
    ) u_profile (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (cnt_value)
    );

    assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                         (state_q == S_WAIT)  || (state_q == S_WRITEBACK);
    assign done        = (state_q == S_FINISH);
    assign run_err     = run_err_q;
    assign rd_index    = cur_q;
    assign wr_index    = cur_q;
    assign set_status  = (state_q == S_WRITEBACK);
    assign set_profile = (state_q == S_WRITEBACK);
    assign wr_status   = (state_q != S_WRITEBACK) ? '0 : (slot_err_q ? STAT_ERROR : STAT_DONE);
    assign wr_profile  = (state_q == S_WRITEBACK) ? cnt_value : '0;
    assign mm2s_valid  = mm2s_valid_q;
    assign mm2s_addr   = src_addr_q;
    assign mm2s_size   = src_size_q;
    assign s2mm_valid  = s2mm_valid_q;
    assign s2mm_addr   = des_addr_q;
    assign s2mm_size   = des_size_q;

endmodule

// File: tb/tb_slot_sequencer.sv
// tb/tb_slot_sequencer.sv - directed self-checking bench for slot_sequencer
module tb_slot_sequencer;
    localparam int IW = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  start_index;
    logic [3:0]  slot_count;
    logic        busy, done, run_err;
    logic [2:0]  rd_index, wr_index;
    logic [31:0] rd_src_addr, rd_des_addr, mm2s_addr, s2mm_addr, wr_profile;
    logic [25:0] rd_src_size, rd_des_size, mm2s_size, s2mm_size;
    logic [1:0]  rd_status, wr_status;
    logic        set_status, set_profile;
    logic        mm2s_valid, mm2s_ready, mm2s_done, mm2s_err;
    logic        s2mm_valid, s2mm_ready, s2mm_done, s2mm_err;

    logic [31:0] t_src_addr [8];
    logic [25:0] t_src_size [8];
    logic [31:0] t_des_addr [8];
    logic [25:0] t_des_size [8];
    logic [1:0]  t_status   [8];

    int m_ready_delay = 0, m_done_delay = 5, m_err_cmd = -1;
    int s_ready_delay = 0, s_done_delay = 5, s_err_cmd = -1;
    int m_wait = 0, m_pend = 0, s_wait = 0, s_pend = 0;
    logic m_perr = 1'b0, s_perr = 1'b0;

    logic [31:0] m_addr_q[$], s_addr_q[$], wb_prof_q[$];
    logic [25:0] m_size_q[$], s_size_q[$];
    logic [2:0]  wb_idx_q[$], rd_q[$];
    logic [1:0]  wb_st_q[$];
    int done_cnt = 0, busy_cnt = 0, m_valid_cyc = 0, s_valid_cyc = 0, strobe_split = 0;
    logic prev_busy = 1'b0;
    logic [2:0] prev_rd = 3'd0;

    int tests_run = 0, tests_failed = 0;

    always #5 clk = ~clk;

    assign rd_src_addr = t_src_addr[rd_index];
    assign rd_src_size = t_src_size[rd_index];
    assign rd_des_addr = t_des_addr[rd_index];
    assign rd_des_size = t_des_size[rd_index];
    assign rd_status   = t_status[rd_index];

    slot_sequencer #(
        .INDEX_WIDTH(IW), .SRC_ADDR_WIDTH(32), .SRC_SIZE_WIDTH(26),
        .DST_ADDR_WIDTH(32), .DST_SIZE_WIDTH(26), .STATUS_WIDTH(2), .PROFILE_WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .start_index(start_index), .slot_count(slot_count),
        .busy(busy), .done(done), .run_err(run_err), .rd_index(rd_index),
        .rd_src_addr(rd_src_addr), .rd_src_size(rd_src_size), .rd_des_addr(rd_des_addr),
        .rd_des_size(rd_des_size), .rd_status(rd_status), .wr_index(wr_index),
        .wr_status(wr_status), .wr_profile(wr_profile), .set_status(set_status),
        .set_profile(set_profile), .mm2s_valid(mm2s_valid), .mm2s_ready(mm2s_ready),
        .mm2s_addr(mm2s_addr), .mm2s_size(mm2s_size), .mm2s_done(mm2s_done), .mm2s_err(mm2s_err),
        .s2mm_valid(s2mm_valid), .s2mm_ready(s2mm_ready), .s2mm_addr(s2mm_addr),
        .s2mm_size(s2mm_size), .s2mm_done(s2mm_done), .s2mm_err(s2mm_err)
    );

    // Source DMA engine: accepts after m_ready_delay cycles, completes m_done_delay cycles later.
    initial begin
        mm2s_ready = 1'b0; mm2s_done = 1'b0; mm2s_err = 1'b0;
        forever begin
            @(negedge clk);
            mm2s_done = 1'b0; mm2s_err = 1'b0;
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin mm2s_done = 1'b1; mm2s_err = m_perr; end
            end
            if (mm2s_valid && !mm2s_ready) begin
                if (m_wait >= m_ready_delay) begin
                    mm2s_ready = 1'b1; m_pend = m_done_delay; m_wait = 0;
                    m_perr = (m_addr_q.size() == m_err_cmd);
                    m_addr_q.push_back(mm2s_addr); m_size_q.push_back(mm2s_size);
                end else m_wait++;
            end else mm2s_ready = 1'b0;
        end
    end

    initial begin
        s2mm_ready = 1'b0; s2mm_done = 1'b0; s2mm_err = 1'b0;
        forever begin
            @(negedge clk);
            s2mm_done = 1'b0; s2mm_err = 1'b0;
            if (s_pend > 0) begin
                s_pend--;
                if (s_pend == 0) begin s2mm_done = 1'b1; s2mm_err = s_perr; end
            end
            if (s2mm_valid && !s2mm_ready) begin
                if (s_wait >= s_ready_delay) begin
                    s2mm_ready = 1'b1; s_pend = s_done_delay; s_wait = 0;
                    s_perr = (s_addr_q.size() == s_err_cmd);
                    s_addr_q.push_back(s2mm_addr); s_size_q.push_back(s2mm_size);
                end else s_wait++;
            end else s2mm_ready = 1'b0;
        end
    end

    // Observer for write-backs, read indices and pulse counts.
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (mm2s_valid) m_valid_cyc++;
            if (s2mm_valid) s_valid_cyc++;
            if (set_status && set_profile) begin
                wb_idx_q.push_back(wr_index); wb_st_q.push_back(wr_status); wb_prof_q.push_back(wr_profile);
            end else if (set_status || set_profile) strobe_split++;
            if (busy && (!prev_busy || rd_index != prev_rd)) rd_q.push_back(rd_index);
            prev_busy = busy; prev_rd = rd_index;
        end
    end

    task automatic set_slot(input int i, input logic [1:0] st, input logic [31:0] sa,
                            input logic [25:0] ss, input logic [31:0] da, input logic [25:0] ds);
        t_status[i] = st; t_src_addr[i] = sa; t_src_size[i] = ss; t_des_addr[i] = da; t_des_size[i] = ds;
    endtask

    task automatic start_run(input logic [2:0] si, input logic [3:0] cnt);
        @(negedge clk);
        start_index = si; slot_count = cnt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit timed_out);
        int n = 0;
        while (done_cnt == base && n < 600) begin @(negedge clk); n++; end
        timed_out = (done_cnt == base);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, run_err, set_status, set_profile, mm2s_valid, s2mm_valid} !== 7'b0) begin
            tests_failed++; $display("FAIL reset_flags: got %b required 0000000",
                {busy, done, run_err, set_status, set_profile, mm2s_valid, s2mm_valid});
        end
        tests_run++;
        if ({rd_index, wr_index, wr_status, wr_profile, mm2s_addr, mm2s_size, s2mm_addr, s2mm_size} !== '0) begin
            tests_failed++; $display("FAIL reset_data: rd_index=%0h wr_index=%0h wr_profile=%0h mm2s_addr=%0h required all 0",
                rd_index, wr_index, wr_profile, mm2s_addr);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int mb, sb, wb, db; bit to;
        for (int i = 0; i < 8; i++) set_slot(i, 2'd0, 32'h0, 26'h0, 32'h0, 26'h0);
        set_slot(2, 2'd1, 32'h1000_0200, 26'h40, 32'h2000_0200, 26'h80);
        set_slot(3, 2'd1, 32'h1000_0300, 26'h1234, 32'h2000_0300, 26'h3FF_FFFF);
        m_ready_delay = 0; m_done_delay = 5; s_ready_delay = 0; s_done_delay = 5;
        mb = m_addr_q.size(); sb = s_addr_q.size(); wb = wb_idx_q.size(); db = done_cnt;
        start_run(3'd2, 4'd2);
        @(negedge clk);
        start_index = 3'd5; slot_count = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(db, to);
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL basic_timeout: done not seen, required within 600 cycles"); end
        tests_run++;
        if (m_addr_q.size() - mb != 2 || s_addr_q.size() - sb != 2) begin
            tests_failed++; $display("FAIL basic_cmd_count: mm2s=%0d s2mm=%0d required 2 and 2",
                m_addr_q.size() - mb, s_addr_q.size() - sb);
        end
        tests_run++;
        if (m_addr_q[mb] !== 32'h1000_0200 || m_size_q[mb] !== 26'h40 ||
            m_addr_q[mb+1] !== 32'h1000_0300 || m_size_q[mb+1] !== 26'h1234) begin
            tests_failed++; $display("FAIL basic_mm2s_cmds: got %0h/%0h %0h/%0h required 10000200/40 10000300/1234",
                m_addr_q[mb], m_size_q[mb], m_addr_q[mb+1], m_size_q[mb+1]);
        end
        tests_run++;
        if (s_addr_q[sb] !== 32'h2000_0200 || s_size_q[sb] !== 26'h80 ||
            s_addr_q[sb+1] !== 32'h2000_0300 || s_size_q[sb+1] !== 26'h3FF_FFFF) begin
            tests_failed++; $display("FAIL basic_s2mm_cmds: got %0h/%0h %0h/%0h required 20000200/80 20000300/3ffffff",
                s_addr_q[sb], s_size_q[sb], s_addr_q[sb+1], s_size_q[sb+1]);
        end
        tests_run++;
        if (wb_idx_q.size() - wb != 2 || wb_idx_q[wb] !== 3'd2 || wb_idx_q[wb+1] !== 3'd3) begin
            tests_failed++; $display("FAIL basic_wb_index: count=%0d first=%0d second=%0d required 2 writes to 2,3",
                wb_idx_q.size() - wb, wb_idx_q[wb], wb_idx_q[wb+1]);
        end
        tests_run++;
        if (wb_st_q[wb] !== 2'd2 || wb_st_q[wb+1] !== 2'd2 || wb_prof_q[wb] !== 32'd6 || wb_prof_q[wb+1] !== 32'd6) begin
            tests_failed++; $display("FAIL basic_wb_data: status %0d,%0d profile %0d,%0d required status 2,2 profile 6,6",
                wb_st_q[wb], wb_st_q[wb+1], wb_prof_q[wb], wb_prof_q[wb+1]);
        end
        tests_run++;
        if (done_cnt - db != 1 || run_err !== 1'b0 || strobe_split != 0) begin
            tests_failed++; $display("FAIL basic_done: done pulses=%0d run_err=%b split strobes=%0d required 1, 0, 0",
                done_cnt - db, run_err, strobe_split);
        end
    endtask

    task automatic test_wrap;
        int rb, wb, db; bit to;
        set_slot(7, 2'd1, 32'h700, 26'h7, 32'h770, 26'h7);
        set_slot(0, 2'd1, 32'h000, 26'h1, 32'h010, 26'h1);
        set_slot(1, 2'd1, 32'h100, 26'h2, 32'h110, 26'h2);
        m_done_delay = 2; s_done_delay = 2;
        rb = rd_q.size(); wb = wb_idx_q.size(); db = done_cnt;
        start_run(3'd7, 4'd3);
        wait_done(db, to);
        tests_run++;
        if (to || rd_q.size() - rb != 3 || rd_q[rb] !== 3'd7 || rd_q[rb+1] !== 3'd0 || rd_q[rb+2] !== 3'd1) begin
            tests_failed++; $display("FAIL wrap_rd_index: timeout=%0d count=%0d seq=%0d,%0d,%0d required 7,0,1",
                to, rd_q.size() - rb, rd_q[rb], rd_q[rb+1], rd_q[rb+2]);
        end
        tests_run++;
        if (wb_idx_q.size() - wb != 3 || wb_idx_q[wb] !== 3'd7 || wb_idx_q[wb+1] !== 3'd0 || wb_idx_q[wb+2] !== 3'd1) begin
            tests_failed++; $display("FAIL wrap_wb_index: count=%0d seq=%0d,%0d,%0d required 7,0,1",
                wb_idx_q.size() - wb, wb_idx_q[wb], wb_idx_q[wb+1], wb_idx_q[wb+2]);
        end
        tests_run++;
        if (wb_prof_q[wb+2] !== 32'd3 || done_cnt - db != 1) begin
            tests_failed++; $display("FAIL wrap_profile_done: profile=%0d done pulses=%0d required 3 and 1",
                wb_prof_q[wb+2], done_cnt - db);
        end
    endtask

    task automatic test_zero_src;
        int mb, sb, wb, db, mv; bit to;
        set_slot(4, 2'd1, 32'hDEAD_0000, 26'h0, 32'h4000_0000, 26'h100);
        s_done_delay = 3;
        mb = m_addr_q.size(); sb = s_addr_q.size(); wb = wb_idx_q.size(); db = done_cnt; mv = m_valid_cyc;
        start_run(3'd4, 4'd1);
        wait_done(db, to);
        tests_run++;
        if (to || m_valid_cyc != mv || m_addr_q.size() != mb) begin
            tests_failed++; $display("FAIL zero_src_mm2s: timeout=%0d mm2s_valid cycles=%0d required 0",
                to, m_valid_cyc - mv);
        end
        tests_run++;
        if (s_addr_q.size() - sb != 1 || s_addr_q[sb] !== 32'h4000_0000 || s_size_q[sb] !== 26'h100) begin
            tests_failed++; $display("FAIL zero_src_s2mm: count=%0d addr=%0h size=%0h required 1, 40000000, 100",
                s_addr_q.size() - sb, s_addr_q[sb], s_size_q[sb]);
        end
        tests_run++;
        if (wb_idx_q.size() - wb != 1 || wb_idx_q[wb] !== 3'd4 || wb_st_q[wb] !== 2'd2 || wb_prof_q[wb] !== 32'd4) begin
            tests_failed++; $display("FAIL zero_src_wb: idx=%0d status=%0d profile=%0d required 4, 2, 4",
                wb_idx_q[wb], wb_st_q[wb], wb_prof_q[wb]);
        end
    endtask

    task automatic test_zero_both;
        int wb, db, mv, sv; bit to;
        set_slot(0, 2'd1, 32'h55, 26'h0, 32'h66, 26'h0);
        wb = wb_idx_q.size(); db = done_cnt; mv = m_valid_cyc; sv = s_valid_cyc;
        start_run(3'd0, 4'd1);
        wait_done(db, to);
        tests_run++;
        if (to || m_valid_cyc != mv || s_valid_cyc != sv) begin
            tests_failed++; $display("FAIL zero_both_valid: timeout=%0d valid cycles=%0d/%0d required 0/0",
                to, m_valid_cyc - mv, s_valid_cyc - sv);
        end
        tests_run++;
        if (wb_idx_q.size() - wb != 1 || wb_st_q[wb] !== 2'd2 || wb_prof_q[wb] !== 32'd1) begin
            tests_failed++; $display("FAIL zero_both_wb: count=%0d status=%0d profile=%0d required 1, 2, 1",
                wb_idx_q.size() - wb, wb_st_q[wb], wb_prof_q[wb]);
        end
    endtask

    task automatic test_error;
        int rb, wb, db; bit to;
        for (int i = 0; i < 3; i++) set_slot(i, 2'd1, 32'h3000 + 32'(i), 26'h10, 32'h4000 + 32'(i), 26'h10);
        m_done_delay = 2; s_done_delay = 2;
        m_err_cmd = m_addr_q.size() + 1;
        rb = rd_q.size(); wb = wb_idx_q.size(); db = done_cnt;
        start_run(3'd0, 4'd3);
        wait_done(db, to);
        m_err_cmd = -1;
        tests_run++;
        if (to || wb_idx_q.size() - wb != 2 || wb_st_q[wb] !== 2'd2 || wb_idx_q[wb+1] !== 3'd1 || wb_st_q[wb+1] !== 2'd3) begin
            tests_failed++; $display("FAIL error_wb: count=%0d status=%0d,%0d idx1=%0d required 2 writes, status 2,3, idx 1",
                wb_idx_q.size() - wb, wb_st_q[wb], wb_st_q[wb+1], wb_idx_q[wb+1]);
        end
        tests_run++;
        if (rd_q.size() - rb != 2 || rd_q[rb+1] !== 3'd1) begin
            tests_failed++; $display("FAIL error_no_fetch: fetched %0d slots, last=%0d required 2 slots ending at 1",
                rd_q.size() - rb, rd_q[rd_q.size()-1]);
        end
        tests_run++;
        if (run_err !== 1'b1 || done_cnt - db != 1) begin
            tests_failed++; $display("FAIL error_run_err: run_err=%b done pulses=%0d required 1 and 1", run_err, done_cnt - db);
        end
    endtask

    task automatic test_zero_count;
        int db, bb; bit to;
        db = done_cnt; bb = busy_cnt;
        start_run(3'd3, 4'd0);
        wait_done(db, to);
        tests_run++;
        if (to || done_cnt - db != 1 || busy_cnt != bb || run_err !== 1'b0) begin
            tests_failed++; $display("FAIL zero_count: done pulses=%0d busy cycles=%0d run_err=%b required 1, 0, 0",
                done_cnt - db, busy_cnt - bb, run_err);
        end
    endtask

    task automatic test_empty;
        int mb, sb, wb, db, rb; bit to;
        set_slot(5, 2'd0, 32'h5000, 26'h20, 32'h6000, 26'h20);
        mb = m_addr_q.size(); sb = s_addr_q.size(); wb = wb_idx_q.size(); db = done_cnt; rb = rd_q.size();
        start_run(3'd5, 4'd2);
        wait_done(db, to);
        tests_run++;
        if (to || m_addr_q.size() != mb || s_addr_q.size() != sb || wb_idx_q.size() != wb) begin
            tests_failed++; $display("FAIL empty_no_activity: cmds=%0d/%0d writes=%0d required 0/0 and 0",
                m_addr_q.size() - mb, s_addr_q.size() - sb, wb_idx_q.size() - wb);
        end
        tests_run++;
        if (run_err !== 1'b1 || done_cnt - db != 1 || rd_q.size() - rb != 1 || rd_q[rb] !== 3'd5) begin
            tests_failed++; $display("FAIL empty_run_err: run_err=%b done pulses=%0d fetched=%0d required 1, 1, 1",
                run_err, done_cnt - db, rd_q.size() - rb);
        end
    endtask

    task automatic test_stall_reset;
        int wb, db, n, bad; bit to;
        set_slot(6, 2'd1, 32'hABCD_0006, 26'h1_2345, 32'hBEEF_0006, 26'h2_0000);
        m_ready_delay = 10; m_done_delay = 40; s_ready_delay = 0; s_done_delay = 40;
        wb = wb_idx_q.size(); db = done_cnt;
        start_run(3'd6, 4'd1);
        n = 0;
        while (!mm2s_valid && n < 20) begin @(negedge clk); n++; end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (mm2s_valid !== 1'b1 || mm2s_addr !== 32'hABCD_0006 || mm2s_size !== 26'h1_2345) bad++;
            @(negedge clk);
        end
        tests_run++;
        if (n >= 20 || bad != 0) begin
            tests_failed++; $display("FAIL stall_stable: wait=%0d unstable cycles=%0d required valid seen and 0", n, bad);
        end
        n = 0;
        while (mm2s_valid && n < 20) begin @(negedge clk); n++; end
        to = (n >= 20);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (to || {busy, done, run_err, set_status, set_profile, mm2s_valid, s2mm_valid} !== 7'b0 ||
            {rd_index, wr_index, wr_profile, mm2s_addr, mm2s_size, s2mm_addr, s2mm_size} !== '0) begin
            tests_failed++; $display("FAIL mid_run_reset: timeout=%0d busy=%b mm2s_valid=%b mm2s_addr=%0h rd_index=%0d required all 0",
                to, busy, mm2s_valid, mm2s_addr, rd_index);
        end
        reset = 1'b0;
        m_ready_delay = 0;
        repeat (60) @(negedge clk);
        tests_run++;
        if (wb_idx_q.size() != wb || done_cnt != db || busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_no_writeback: writes=%0d done pulses=%0d busy=%b required 0, 0, 0",
                wb_idx_q.size() - wb, done_cnt - db, busy);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_index = 3'd0; slot_count = 4'd0;
        for (int i = 0; i < 8; i++) set_slot(i, 2'd0, 32'h0, 26'h0, 32'h0, 26'h0);
        test_reset();
        test_basic();
        test_wrap();
        test_zero_src();
        test_zero_both();
        test_error();
        test_zero_count();
        test_empty();
        test_stall_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
